// File: rtl/prbs16_checker_pkg.sv
// rtl/prbs16_checker_pkg.sv - shared constants and state type for the PRBS16 checker
package prbs_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 14;
  localparam int TAP_C  = 12;
  localparam int TAP_D  = 3;

  // XNOR feedback never leaves all-ones, so it is the lock-up state
  localparam logic [LFSR_W-1:0] LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/prbs16_checker_if.sv
// rtl/prbs16_checker_if.sv - serial input and status bundle of the PRBS16 checker
interface prbs16_checker_if;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output bit_in, bit_valid, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs16_step.sv
// rtl/prbs16_step.sv - one combinational step of the 16-bit XNOR LFSR
module prbs16_step
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  input  logic              ins,
  output logic              p,
  output logic [LFSR_W-1:0] s_next
);

  assign p      = ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
  assign s_next = {s[LFSR_W-2:0], ins};

endmodule

// File: rtl/prbs16_checker.sv
// rtl/prbs16_checker.sv - self-synchronising PRBS16 receive checker with lock and error counters
module prbs16_checker
  import prbs_pkg::*;
#(
  parameter int CHECK_BITS  = 32,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 8
) (
  input logic              CLK,
  input logic              EN,
  prbs16_checker_if.slave  bus
);

  localparam int FILL_W = $clog2(LFSR_W);
  localparam int CHK_W  = (CHECK_BITS  > 1) ? $clog2(CHECK_BITS)  : 1;
  localparam int WIN_W  = (WINDOW      > 1) ? $clog2(WINDOW)      : 1;
  localparam int ERR_W  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);
  localparam logic [CHK_W-1:0]  CHK_LAST  = CHK_W'(CHECK_BITS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(LOSS_THRESH - 1);

  state_t              state;
  logic [LFSR_W-1:0]   s;
  logic [LFSR_W-1:0]   s_next;
  logic                p;
  logic                ins;
  logic                mismatch;
  logic                lockup;
  logic [FILL_W-1:0]   fill_cnt;
  logic [CHK_W-1:0]    chk_cnt;
  logic [WIN_W-1:0]    win_bits;
  logic [ERR_W-1:0]    win_err;
  logic                locked;
  logic                err_pulse;
  logic [15:0]         err_count;
  logic [31:0]         bit_count;

  // Once filled, the checker free-runs on its own prediction so line errors never corrupt s
  assign ins      = (state == HUNT) ? bus.bit_in : p;
  assign mismatch = bus.bit_in ^ p;
  assign lockup   = (s == LOCKUP);

  prbs16_step u_step (
    .s      (s),
    .ins    (ins),
    .p      (p),
    .s_next (s_next)
  );

  always_ff @(posedge CLK) begin
    if (!EN) begin
      state     <= HUNT;
      s         <= '0;
      fill_cnt  <= '0;
      chk_cnt   <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.bit_valid) begin
        s <= s_next;
        case (state)
          HUNT: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_LAST) begin
              state   <= VERIFY;
              chk_cnt <= '0;
            end
          end
          VERIFY: begin
            if (lockup) begin
              state    <= HUNT;
              fill_cnt <= '0;
            end else if (mismatch) begin
              err_pulse <= 1'b1;
              state     <= HUNT;
              fill_cnt  <= '0;
            end else if (chk_cnt == CHK_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              chk_cnt <= chk_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (lockup) begin
              state    <= HUNT;
              locked   <= 1'b0;
              fill_cnt <= '0;
            end else begin
              bit_count <= bit_count + 1'b1;
              if (mismatch) begin
                err_pulse <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
              end
              // Loss is tested before the window wrap so a final-bit threshold hit still drops lock
              if (mismatch && win_err == ERR_LAST) begin
                state    <= HUNT;
                locked   <= 1'b0;
                fill_cnt <= '0;
                win_bits <= '0;
                win_err  <= '0;
              end else if (win_bits == WIN_LAST) begin
                win_bits <= '0;
                win_err  <= '0;
              end else begin
                win_bits <= win_bits + 1'b1;
                if (mismatch) win_err <= win_err + 1'b1;
              end
            end
          end
          default: begin
            state    <= HUNT;
            fill_cnt <= '0;
          end
        endcase
      end
      if (bus.clear_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;
  assign bus.bit_count = bit_count;

endmodule
